// File: rtl/pll_reset_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable synchronized lock, then releases system reset.
// Latency: lock_i passes 2 sync flops and outputs are registered; there is no backpressure, retries continue indefinitely.
module pll_reset_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_WAIT      = 1024,
  parameter int unsigned TIMEOUT        = 65535
) (
  input  logic       clock,
  input  logic       areset_n,
  input  logic       lock_i,
  input  logic       clear_i,
  output logic       pll_reset_o,
  output logic       sys_rst_no,
  output logic       locked_o,
  output logic       lost_o,
  output logic [3:0] retries_o
);

  typedef enum logic [1:0] {
    ST_RST,
    ST_WAIT,
    ST_STABLE,
    ST_RUN
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_WAIT - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic        lock_s;
  logic        retry_ev, lost_ev;
  logic [3:0]  retries_q, retries_d;
  logic        lost_q, lost_d;
  logic        pll_reset_q, sys_rst_n_q, locked_q;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], lock_i};
    end
  end

  assign lock_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    retry_ev = 1'b0;
    lost_ev  = 1'b0;
    case (state_q)
      ST_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ST_RST;
          retry_ev = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // RUN has no terminal count, so the counter holds instead of wrapping.
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = ST_RST;
          lost_ev = 1'b1;
        end
      end
      default: state_d = ST_RST;
    endcase
    if (state_d != state_q) cnt_d = 16'd0;

    retries_d = retries_q;
    lost_d    = lost_q;
    if (clear_i) begin
      retries_d = 4'd0;
      lost_d    = 1'b0;
    end else begin
      if (retry_ev && (retries_q != 4'hF)) retries_d = retries_q + 4'd1;
      if (lost_ev) lost_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_RST;
      cnt_q       <= 16'd0;
      retries_q   <= 4'd0;
      lost_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      lost_q      <= lost_d;
      // Decoding from state_d lets outputs move on the same edge as the state.
      pll_reset_q <= (state_d == ST_RST);
      sys_rst_n_q <= (state_d == ST_RUN);
      locked_q    <= (state_d == ST_RUN);
    end
  end

  assign pll_reset_o = pll_reset_q;
  assign sys_rst_no  = sys_rst_n_q;
  assign locked_o    = locked_q;
  assign lost_o      = lost_q;
  assign retries_o   = retries_q;

endmodule

// File: doc/pll_reset_supervisor.md
PLL_RESET_SUPERVISOR -- requirements
Module: pll_reset_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles that pll_reset_o is held high per PLL reset pulse; range 1..65535.
REQ-002 SHALL have parameter LOCK_WAIT, default 1024: consecutive synchronized-lock cycles required before sys_rst_no releases; range 1..65535.
REQ-003 SHALL have parameter TIMEOUT, default 65535: cycles allowed in WAIT for lock before a PLL reset retry; range 1..65535.
REQ-004 clock  input  1  free-running PLL reference clock; not the PLL output.
REQ-005 areset_n  input  1  asynchronous, active-low reset.
REQ-006 lock_i  input  1  PLL lock output, asynchronous to clock.
REQ-007 clear_i  input  1  single-cycle clear of lost_o and retries_o.
REQ-008 pll_reset_o  output  1  drives the PLL RESET pin, active-high.
REQ-009 sys_rst_no  output  1  system reset, active-low; high only in RUN.
REQ-010 locked_o  output  1  high only in RUN.
REQ-011 lost_o  output  1  sticky flag set on lock loss in RUN.
REQ-012 retries_o  output  4  saturating count of timeout-triggered retries.

Function
REQ-013 lock_i SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only, giving 2 cycles of input latency.
REQ-014 FSM states SHALL be RST, WAIT, STABLE and RUN, with one 16-bit cycle counter cnt that is cleared on every state transition.
REQ-015 RST: pll_reset_o=1; SHALL go to WAIT when cnt==PLL_RST_CYCLES-1, so the pulse lasts exactly PLL_RST_CYCLES cycles.
REQ-016 WAIT: pll_reset_o=0; lock_s=1 SHALL go to STABLE; else cnt==TIMEOUT-1 SHALL go to RST and increment retries_o, saturating at 15.
REQ-017 STABLE: lock_s=0 SHALL return to WAIT with cnt cleared; else cnt==LOCK_WAIT-1 SHALL go to RUN.
REQ-018 Lock glitches in STABLE SHALL NOT increment retries_o or set lost_o.
REQ-019 RUN: sys_rst_no=1, locked_o=1; lock_s=0 SHALL go to RST, set lost_o, and drive sys_rst_no=0 and locked_o=0 on the next edge.
REQ-020 All outputs SHALL be registered and are decoded from the next-state value, so they change on the same edge as the state.
REQ-021 cnt SHALL never wrap, because each state exits at or before its terminal count.
REQ-022 clear_i SHALL zero retries_o and lost_o next cycle without affecting the FSM.
REQ-023 clear_i has priority over a simultaneous set or increment: both clear, and the event is dropped.
REQ-024 The FSM SHALL retry indefinitely; retries_o saturating does not stop retries.

Reset
REQ-025 While areset_n=0, the block SHALL be in state RST with cnt=0, synchronizer=0, pll_reset_o=1, sys_rst_no=0, locked_o=0, lost_o=0, retries_o=0.
REQ-026 areset_n assertion SHALL take effect immediately, with no clock edge required, including mid-RUN.
REQ-027 Release SHALL be synchronous to clock, and a full PLL_RST_CYCLES pulse SHALL follow.

Verification (PLL_RST_CYCLES=4, LOCK_WAIT=8, TIMEOUT=32)
REQ-028 Release areset_n, then raise lock_i on cycle 10 -> pll_reset_o high for cycles 0-3, sys_rst_no rises 2+8 cycles after lock_i, retries_o=0.
REQ-029 Hold lock_i=0 -> pll_reset_o repeats 4-high/32-low; retries_o counts 1,2,..,15 and holds at 15.
REQ-030 In STABLE, pulse lock_i low for 3 cycles at count 5 -> count restarts; RUN is entered 8 cycles after lock_s returns high; lost_o=0.
REQ-031 In RUN, drop lock_i -> after 2-cycle sync, sys_rst_no=0, locked_o=0, lost_o=1, pll_reset_o=1 for 4 cycles; relock returns to RUN with lost_o still 1.
REQ-032 Assert clear_i on the same cycle as a retry increment -> retries_o=0; then assert areset_n=0 mid-RUN -> sys_rst_no=0 with no clock edge.
